// File: rtl/mem_port_pkg.sv
// Shared definitions for the two-phase memory port (request phase plus
// in-order read-data phase).
//
// Contents:
//   MEM_DATA_W / MEM_ADDR_W / MEM_BE_W : port field widths
//   MEM_OOB_DATA                       : data returned for out-of-range reads
//   req_kind_e                         : decoded kind of the request accepted this cycle
//   rd_slot_t                          : one stage of the read-latency pipeline
//   be_merge()                         : byte-enable merge of write data into a word
package mem_port_pkg;

    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_BE_W   = 4;

    localparam logic [MEM_DATA_W-1:0] MEM_OOB_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_WRITE,
        REQ_READ
    } req_kind_e;

    typedef struct packed {
        logic                  valid;
        logic [MEM_DATA_W-1:0] data;
    } rd_slot_t;

    // Bytes whose enable bit is set take the write data; the rest keep the old word.
    function automatic logic [MEM_DATA_W-1:0] be_merge(
        input logic [MEM_DATA_W-1:0] old_word,
        input logic [MEM_DATA_W-1:0] wr_data,
        input logic [MEM_BE_W-1:0]   be
    );
        logic [MEM_DATA_W-1:0] merged;
        merged = old_word;
        for (int unsigned b = 0; b < MEM_BE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Response buffer: small synchronous FIFO with occupancy count.
//
// Ports:
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset, empties the FIFO
//   i_push       : write i_push_data (ignored when full)
//   i_push_data  : entry to store
//   i_pop        : drop the head entry (ignored when empty)
//   o_count      : number of stored entries, 0..DEPTH
//   o_head       : oldest entry; 0 when empty
module resp_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [WIDTH-1:0]             o_head
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push & (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = i_pop  & (r_count != '0);

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the two-phase memory port (IDT/vector store).
// Word-addressed storage, fixed read latency, bounded in-order response buffer.
//
// Ports:
//   clk              : clock, rising edge
//   reset            : asynchronous active-low reset (clears storage and all state)
//   mem_valid        : request valid
//   mem_ready        : request accepted this cycle if mem_valid is high
//   mem_address      : byte address, bits [1:0] ignored
//   mem_wr_en        : 1 = write, 0 = read
//   mem_wr_data      : write data
//   mem_wr_size      : byte enables, bit i writes byte i
//   mem_dp_valid     : read data valid
//   mem_dp_ready     : requester accepts read data
//   mem_dp_read_data : read data (held stable while mem_dp_valid is high)
//   err_oob          : sticky out-of-range access flag
//   err_clear        : clears err_oob (a coincident new OOB access wins)
module mem_responder
    import mem_port_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [MEM_ADDR_W-1:0] mem_address,
    input  logic                  mem_wr_en,
    input  logic [MEM_DATA_W-1:0] mem_wr_data,
    input  logic [MEM_BE_W-1:0]   mem_wr_size,
    output logic                  mem_dp_valid,
    input  logic                  mem_dp_ready,
    output logic [MEM_DATA_W-1:0] mem_dp_read_data,
    output logic                  err_oob,
    input  logic                  err_clear
);

    localparam int unsigned WORDS  = 1 << ADDR_BITS;
    localparam int unsigned OCNT_W = $clog2(OUT_DEPTH + 1);

    logic [MEM_DATA_W-1:0] r_mem [WORDS];
    logic [OCNT_W-1:0]     r_out_cnt;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_in_range;
    logic [ADDR_BITS-1:0]  w_index;
    req_kind_e             w_kind;
    logic                  w_rd_acc;
    logic [MEM_DATA_W-1:0] w_rd_data;
    logic                  w_push_v;
    logic [MEM_DATA_W-1:0] w_push_d;
    logic                  w_pop;
    logic [OCNT_W-1:0]     w_fifo_cnt;
    logic [MEM_DATA_W-1:0] w_fifo_head;
    logic                  w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^mem_address[1:0];

    // Outstanding reads cover both the latency pipeline and the buffer, so the
    // buffer can never overflow and the pipeline never needs a stall path.
    assign w_ready    = reset & (r_out_cnt < OCNT_W'(OUT_DEPTH));
    assign w_accept   = mem_valid & w_ready;
    assign w_in_range = (mem_address[MEM_ADDR_W-1:ADDR_BITS+2] == '0);
    assign w_index    = mem_address[ADDR_BITS+1:2];

    always_comb begin
        w_kind = REQ_IDLE;
        if (w_accept) begin
            w_kind = mem_wr_en ? REQ_WRITE : REQ_READ;
        end
    end

    assign w_rd_acc  = (w_kind == REQ_READ);
    assign w_rd_data = w_in_range ? r_mem[w_index] : MEM_OOB_DATA;

    // Storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if ((w_kind == REQ_WRITE) && w_in_range) begin
            r_mem[w_index] <= be_merge(r_mem[w_index], mem_wr_data, mem_wr_size);
        end
    end

    // Latency pipeline: the buffer register itself is the last stage, so only
    // LATENCY-1 pipeline registers sit in front of it.
    if (LATENCY == 1) begin : g_lat1
        assign w_push_v = w_rd_acc;
        assign w_push_d = w_rd_data;
    end else begin : g_pipe
        rd_slot_t r_pipe [LATENCY-1];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int unsigned k = 0; k < LATENCY - 1; k++) begin
                    r_pipe[k] <= '0;
                end
            end else begin
                r_pipe[0] <= '{valid: w_rd_acc, data: w_rd_data};
                for (int unsigned k = 1; k < LATENCY - 1; k++) begin
                    r_pipe[k] <= r_pipe[k-1];
                end
            end
        end

        assign w_push_v = r_pipe[LATENCY-2].valid;
        assign w_push_d = r_pipe[LATENCY-2].data;
    end

    resp_fifo #(
        .WIDTH(MEM_DATA_W),
        .DEPTH(OUT_DEPTH)
    ) u_resp_fifo (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_push      (w_push_v),
        .i_push_data (w_push_d),
        .i_pop       (w_pop),
        .o_count     (w_fifo_cnt),
        .o_head      (w_fifo_head)
    );

    assign w_pop = mem_dp_valid & mem_dp_ready;

    // Outstanding read count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_cnt <= '0;
        end else begin
            case ({w_rd_acc, w_pop})
                2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
                2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // Sticky out-of-range flag; a new OOB access beats a coincident clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_in_range) begin
            r_err <= 1'b1;
        end else if (err_clear) begin
            r_err <= 1'b0;
        end
    end

    assign mem_ready        = w_ready;
    assign mem_dp_valid     = (w_fifo_cnt != '0);
    assign mem_dp_read_data = w_fifo_head;
    assign err_oob          = r_err;

endmodule
